sig_conditioner: RTL and testbench

//  Parametrised successor to the single-bit inverter: per-channel polarity control plus input

---
 rtl/sig_conditioner_pkg.sv | 16 +
 rtl/sig_conditioner_ch.sv | 87 ++++++++
 rtl/sig_conditioner.sv | 44 ++++
 tb/tb_sig_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sig_conditioner_pkg.sv
// rtl/sig_conditioner_pkg.sv - shared limits, P500 pin-group defaults and helpers for sig_conditioner
package sig_conditioner_pkg;

    localparam int SIG_SYNC_MAX = 3;
    localparam int SIG_FILT_MAX = 15;

    // P500 control-pin group: RDY/IRQ/NMI/RES are active low and idle high on the board
    localparam logic [3:0] SIG_P500_INV_MASK  = 4'hF;
    localparam logic [3:0] SIG_P500_RESET_VAL = 4'hF;

    // Filter counter width: enough to hold FILT_LEN-1, never below one bit
    function automatic int sig_cnt_width(input int filt_len);
        return (filt_len > 1) ? $clog2(filt_len) : 1;
    endfunction

endpackage

// File: rtl/sig_conditioner_ch.sv
// rtl/sig_conditioner_ch.sv - one channel: synchroniser, glitch filter, polarity and edge pulses
module sig_conditioner_ch
    import sig_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic INV         = 1'b1,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic in,
    input  logic pol_inv,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int             CW      = sig_cnt_width(FILT_LEN);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

    logic          s;
    logic          stable;
    logic          stable_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          out_next;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] chain;

            // Synchroniser runs every clock regardless of en
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    chain <= {SYNC_STAGES{RESET_VAL}};
                end else begin
                    chain[0] <= in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end
    endgenerate

    // Filter decision: accept a new level after FILT_LEN consecutive mismatching en-ticks
    always_comb begin
        stable_next = stable;
        cnt_next    = cnt;
        if (en) begin
            if (s == stable) begin
                cnt_next = '0;
            end else if (cnt == CNT_MAX) begin
                stable_next = s;
                cnt_next    = '0;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    assign out_next = stable_next ^ INV ^ pol_inv;

    // Filter state, polarity-corrected output and edge pulses tied to real filter accepts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= RESET_VAL;
            cnt    <= '0;
            out    <= RESET_VAL ^ INV ^ pol_inv;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
            out    <= out_next;
            rise   <= (stable_next != stable) && (out_next != out) &&  out_next;
            fall   <= (stable_next != stable) && (out_next != out) && !out_next;
        end
    end

endmodule

// File: rtl/sig_conditioner.sv
// rtl/sig_conditioner.sv - multi-channel input conditioner for asynchronous CPU control pins
module sig_conditioner
    import sig_conditioner_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_LEN    = 4,
    parameter logic [WIDTH-1:0] INV_MASK    = WIDTH'(SIG_P500_INV_MASK),
    parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(SIG_P500_RESET_VAL)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] pol_inv,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int SYNC_USED = (SYNC_STAGES > SIG_SYNC_MAX) ? SIG_SYNC_MAX : SYNC_STAGES;
    localparam int FILT_USED = (FILT_LEN > SIG_FILT_MAX) ? SIG_FILT_MAX :
                               (FILT_LEN < 1) ? 1 : FILT_LEN;

    // Channels are fully independent; the top only slices vectors and picks the mask bits
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sig_conditioner_ch #(
            .SYNC_STAGES (SYNC_USED),
            .FILT_LEN    (FILT_USED),
            .INV         (INV_MASK[i]),
            .RESET_VAL   (RESET_VAL[i])
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .in      (in[i]),
            .pol_inv (pol_inv[i]),
            .out     (out[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_sig_conditioner.sv
// tb/tb_sig_conditioner.sv - scoreboard bench for sig_conditioner (default build and a zero-sync/no-filter build)
module tb_sig_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] in;
    logic [3:0] pol_inv;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;

    always #5 clk = ~clk;

    sig_conditioner u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pol_inv(pol_inv),
        .out(out_a), .rise(rise_a), .fall(fall_a)
    );

    sig_conditioner #(
        .WIDTH(4), .SYNC_STAGES(0), .FILT_LEN(1), .INV_MASK(4'h5), .RESET_VAL(4'hA)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .in(in), .pol_inv(pol_inv),
        .out(out_b), .rise(rise_b), .fall(fall_b)
    );

    typedef struct {
        logic [3:0] o[2];
        logic [3:0] r[2];
        logic [3:0] f[2];
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   done        = 0;

    // Reference model: input seen SYNC_STAGES clocks late; a level is accepted once it has
    // disagreed with the current level for FILT_LEN en-ticks in a row.
    int         m_ss [2] = '{2, 0};
    int         m_fl [2] = '{4, 1};
    logic [3:0] m_inv[2] = '{4'hF, 4'h5};
    logic [3:0] m_rv [2] = '{4'hF, 4'hA};
    logic [3:0] m_hist  [2][$];
    logic [3:0] m_stable[2];
    logic [3:0] m_out   [2];
    int         m_run   [2][4];

    task automatic model_edge(input int k, input logic rst_n, input logic e,
                              input logic [3:0] x, input logic [3:0] p,
                              output logic [3:0] o, output logic [3:0] r, output logic [3:0] f);
        logic [3:0] seen;
        logic [3:0] nst;
        if (!rst_n) begin
            m_stable[k] = m_rv[k];
            m_hist[k].delete();
            for (int j = 0; j < m_ss[k]; j++) m_hist[k].push_back(m_rv[k]);
            for (int c = 0; c < 4; c++) m_run[k][c] = 0;
            o = m_rv[k] ^ m_inv[k] ^ p;
            r = 4'h0;
            f = 4'h0;
        end else begin
            if (m_ss[k] == 0) begin
                seen = x;
            end else begin
                seen = m_hist[k].pop_front();
                m_hist[k].push_back(x);
            end
            nst = m_stable[k];
            if (e) begin
                for (int c = 0; c < 4; c++) begin
                    if (seen[c] != m_stable[k][c]) begin
                        m_run[k][c]++;
                        if (m_run[k][c] >= m_fl[k]) begin
                            nst[c] = seen[c];
                            m_run[k][c] = 0;
                        end
                    end else begin
                        m_run[k][c] = 0;
                    end
                end
            end
            o = nst ^ m_inv[k] ^ p;
            r = (nst ^ m_stable[k]) & (o ^ m_out[k]) & o;
            f = (nst ^ m_stable[k]) & (o ^ m_out[k]) & ~o;
            m_stable[k] = nst;
        end
        m_out[k] = o;
    endtask

    // Drive one clock's worth of inputs (away from the edge) and queue the expected result
    task automatic step(input logic rst_n, input logic e, input logic [3:0] x, input logic [3:0] p);
        exp_t ex;
        @(negedge clk);
        reset_n = rst_n;
        en      = e;
        in      = x;
        pol_inv = p;
        for (int k = 0; k < 2; k++) model_edge(k, rst_n, e, x, p, ex.o[k], ex.r[k], ex.f[k]);
        exp_q.push_back(ex);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: after every edge that has a queued expectation, compare all outputs
    initial begin
        exp_t ex;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk("out_a",  out_a,  ex.o[0]);
                chk("rise_a", rise_a, ex.r[0]);
                chk("fall_a", fall_a, ex.f[0]);
                chk("out_b",  out_b,  ex.o[1]);
                chk("rise_b", rise_b, ex.r[1]);
                chk("fall_b", fall_b, ex.f[1]);
                chk("rise_fall_excl_a", rise_a & fall_a, 4'h0);
            end
        end
    end

    initial begin
        logic [3:0] x;
        logic [3:0] p;
        reset_n = 1'b0; en = 1'b1; in = 4'hF; pol_inv = 4'h0;

        // Reset held for three clocks with idle-high pins
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 4'h0);
        // Clean falling edge on in[0]
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'hE, 4'h0);
        // Three-clock glitch on in[1]
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hC, 4'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'hE, 4'h0);
        // in[2] low with en every 4th clock, then every 6th
        for (int i = 0; i < 24; i++) step(1'b1, (i % 4) == 0, 4'hA, 4'h0);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 4'hE, 4'h0);
        for (int i = 0; i < 36; i++) step(1'b1, (i % 6) == 0, 4'hA, 4'h0);
        // pol_inv[3] toggles with a quiet input
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hA, 4'h8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hA, 4'h0);
        // in[3] falls; pol_inv[3] flips on the same edge the filter accepts
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'h2, 4'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'h2, 4'h8);
        // Back to idle, then reset in the middle of filtering in[0]
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4'hF, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hE, 4'h0);
        step(1'b0, 1'b1, 4'hE, 4'h0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 4'hE, 4'h0);

        // Randomised traffic: slow-changing pins with glitches, sparse en gaps, rare resets
        x = 4'hE;
        p = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7) == 0)  x[c] = ~x[c];
                if ($urandom_range(0, 29) == 0) p[c] = ~p[c];
            end
            step($urandom_range(0, 249) != 0, $urandom_range(0, 3) != 0, x, p);
        end

        // Let the monitor drain; leftover expectations mean the monitor stalled
        for (int i = 0; i < 4; i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
